// File: rtl/divisor_frequencia_multicanal_pkg.sv
// Shared constants for the multichannel clock-enable generator.
// Default divisors are derived from the 50 MHz system clock.
package divisor_frequencia_multicanal_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_128HZ = CLK_HZ / 128;
  localparam int unsigned DIV_MIN   = 2;

  // Channel-select width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: active divisor, shadow divisor, counter, tick and square wave.
// A shadow divisor is adopted only on a period boundary or a restart, so no runt periods.
module divisor_canal #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_rst,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] shd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pend_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] div_sel;
  logic             wrap;

  always_comb begin
    half     = div_reg >> 1;
    wrap     = enable && (cnt_reg == div_reg - CNT_W'(1));
    cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
    // A same-cycle write beats an older pending value.
    div_sel  = wr ? wr_val : (pend_reg ? shd_reg : div_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= div_rst;
      shd_reg  <= div_rst;
      pend_reg <= 1'b0;
      cnt_reg  <= div_rst - CNT_W'(1);
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else if (restart) begin
      div_reg  <= div_sel;
      if (wr) shd_reg <= wr_val;
      pend_reg <= 1'b0;
      cnt_reg  <= div_sel - CNT_W'(1);
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      tick <= wrap;
      if (enable) begin
        cnt_reg <= cnt_next;
        clk_out <= (cnt_next < half);
      end
      if (wrap) begin
        div_reg  <= div_sel;
        pend_reg <= 1'b0;
      end else if (wr) begin
        pend_reg <= 1'b1;
      end
      if (wr) shd_reg <= wr_val;
    end
  end

endmodule

// File: rtl/divisor_frequencia_multicanal.sv
// Multichannel clock-enable generator: load validation, error pulse and NUM_CH divider channels.
// Consumers must use tick as a clock enable; clk_out is for observation/IO only.
module divisor_frequencia_multicanal
  import divisor_frequencia_multicanal_pkg::*;
#(
  parameter  int                        NUM_CH       = 2,
  parameter  int                        CNT_W        = 26,
  parameter  logic [NUM_CH*CNT_W-1:0]   DIV_DEFAULTS = {CNT_W'(DIV_1HZ), CNT_W'(DIV_128HZ)},
  localparam int                        SEL_W        = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              sync_restart,
  output logic              load_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic              sel_ok;
  logic              val_ok;
  logic              load_ok;
  logic [NUM_CH-1:0] wr;

  assign sel_ok  = 32'(ch_sel) < NUM_CH;
  assign val_ok  = div_value >= CNT_W'(DIV_MIN);
  assign load_ok = load && sel_ok && val_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_canal
      assign wr[gi] = load_ok && (ch_sel == SEL_W'(gi));

      divisor_canal #(
        .CNT_W(CNT_W)
      ) u_canal (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .wr      (wr[gi]),
        .wr_val  (div_value),
        .restart (sync_restart),
        .div_rst (DIV_DEFAULTS[gi*CNT_W +: CNT_W]),
        .tick    (tick[gi]),
        .clk_out (clk_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_divisor_frequencia_multicanal.sv
// Directed and randomized bench for divisor_frequencia_multicanal (CNT_W=8, defaults ch0=4, ch1=5).
// The reference tracks each channel's position within its current period using modular arithmetic.
module tb_divisor_frequencia_multicanal;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_DEF = {8'd5, 8'd4};

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              load;
  logic [0:0]        ch_sel;
  logic [CNT_W-1:0]  div_value;
  logic              sync_restart;
  logic              load_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  divisor_frequencia_multicanal #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DIV_DEFAULTS (DIV_DEF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .load         (load),
    .ch_sel       (ch_sel),
    .div_value    (div_value),
    .sync_restart (sync_restart),
    .load_err     (load_err),
    .tick         (tick),
    .clk_out      (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int def_div [NUM_CH] = '{4, 5};
  int m_div   [NUM_CH];
  int m_shd   [NUM_CH];
  int m_phase [NUM_CH];
  bit m_pend  [NUM_CH];
  bit e_tick  [NUM_CH];
  bit e_co    [NUM_CH];
  bit e_err;
  logic [NUM_CH-1:0] prev_tick;
  logic [NUM_CH-1:0] prev_co;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = def_div[i];
      m_shd[i]   = def_div[i];
      m_pend[i]  = 1'b0;
      m_phase[i] = def_div[i] - 1;
      e_tick[i]  = 1'b0;
      e_co[i]    = 1'b0;
    end
    e_err     = 1'b0;
    prev_tick = '0;
    prev_co   = '0;
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit en, input bit ld, input int sel, input int val, input bit rs);
    bit ok;
    bit wr;
    bit boundary;
    enable       = en;
    load         = ld;
    ch_sel       = 1'(sel);
    div_value    = CNT_W'(val);
    sync_restart = rs;
    ok    = ld && (val >= 2) && (sel < NUM_CH);
    e_err = ld && !ok;
    for (int i = 0; i < NUM_CH; i++) begin
      wr = ok && (sel == i);
      if (rs) begin
        if (wr) begin
          m_shd[i] = val;
          m_div[i] = val;
        end else if (m_pend[i]) begin
          m_div[i] = m_shd[i];
        end
        m_pend[i]  = 1'b0;
        m_phase[i] = m_div[i] - 1;
        e_tick[i]  = 1'b0;
        e_co[i]    = 1'b0;
      end else begin
        boundary  = en && (((m_phase[i] + 1) % m_div[i]) == 0);
        e_tick[i] = boundary;
        if (en) begin
          m_phase[i] = (m_phase[i] + 1) % m_div[i];
          e_co[i]    = m_phase[i] < (m_div[i] / 2);
        end
        if (boundary) begin
          if (wr) m_div[i] = val;
          else if (m_pend[i]) m_div[i] = m_shd[i];
          m_pend[i] = 1'b0;
        end else if (wr) begin
          m_pend[i] = 1'b1;
        end
        if (wr) m_shd[i] = val;
      end
    end
    @(posedge clk);
    #1;
    $display("cycle t=%0t en=%0b ld=%0b sel=%0d val=%0d rs=%0b -> tick=%b clk_out=%b load_err=%0b",
             $time, en, ld, sel, val, rs, tick, clk_out, load_err);
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(e_tick[i]));
      chk($sformatf("clk_out%0d", i), 32'(clk_out[i]), 32'(e_co[i]));
      chk($sformatf("tick_width%0d", i), 32'(prev_tick[i] & tick[i]), 32'd0);
      chk($sformatf("tick_rise%0d", i), 32'(tick[i] & ~(clk_out[i] & ~prev_co[i])), 32'd0);
    end
    chk("load_err", 32'(load_err), 32'(e_err));
    prev_tick = tick;
    prev_co   = clk_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    load         = 1'b0;
    ch_sel       = '0;
    div_value    = '0;
    sync_restart = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    #3 reset_n = 1'b1;

    // Default divisors, both channels tick on the first enabled cycle.
    repeat (12) step(1, 0, 0, 0, 0);

    // Load ch0=6 mid-period: current period keeps old divisor.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 6, 0);
    repeat (14) step(1, 0, 0, 0, 0);

    // Illegal divisors are rejected.
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);

    // Enable low for 7 cycles mid-period.
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0, 0);

    // ch1 pending 3 then sync_restart.
    step(1, 1, 1, 3, 0);
    step(1, 0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 0, 0);

    // Load and restart in the same cycle, restart while disabled.
    step(1, 1, 0, 2, 1);
    repeat (5) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 9)), $urandom_range(0, 40) == 0);
    end

    // Async reset mid-period with a pending load.
    step(1, 1, 0, 7, 0);
    step(1, 0, 0, 0, 0);
    load = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_clk_out", 32'(clk_out), 32'd0);
    chk("async_load_err", 32'(load_err), 32'd0);
    model_reset();
    #2 reset_n = 1'b1;
    repeat (12) step(1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
